riscv_mc_controller: RTL and testbench

Multicycle control unit that generates every datapath control strobe from the fetched instruction fields and the ALU zero flag. It sits beside the RISC-V datapath as the instruction-decode end of the control interface: the datapath consumes the strobes, and this block consumes instruction fields and the zero flag. It supports lw, sw, R-type ALU, I-type ALU, beq and jal, with a memory-ready handshake and a retired-instruction counter.

---
 rtl/riscv_ctrl_pkg.sv | 55 +++++
 rtl/riscv_alu_decoder.sv | 31 +++
 rtl/riscv_mc_controller.sv | 155 +++++++++++++++
 tb/tb_riscv_mc_controller.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V control unit: FSM states,
// opcodes, ALU control codes and datapath mux selects.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_BEQ,
        S_JAL,
        S_FAULT
    } state_e;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Coarse ALU request from the FSM; FUNCT defers to the instruction fields.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/riscv_alu_decoder.sv
// Combinational ALU control decode from the FSM's ALU request and the
// instruction's funct fields.
module riscv_alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [1:0] alu_op_i,
    input  logic [2:0] funct3_i,
    input  logic       op5_i,
    input  logic       funct7b5_i,
    output logic [2:0] alu_control_o
);

    always_comb begin
        alu_control_o = ALU_ADD;
        case (alu_op_i)
            ALUOP_SUB: alu_control_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3_i)
                    // instr[30] only selects sub for register-register ops; addi ignores it
                    3'b000:  alu_control_o = (op5_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control_o = ALU_SLT;
                    3'b110:  alu_control_o = ALU_OR;
                    3'b111:  alu_control_o = ALU_AND;
                    default: alu_control_o = ALU_ADD;
                endcase
            end
            default: alu_control_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/riscv_mc_controller.sv
// Multicycle RISC-V control FSM: Moore state decode of all datapath strobes,
// memory-ready handshake, sticky fault state and retired-instruction counter.
module riscv_mc_controller
    import riscv_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [6:0]       i_op,
    input  logic [2:0]       i_funct3,
    input  logic             i_funct7b5,
    input  logic             i_zero,
    input  logic             i_mem_ready,
    output logic             o_pc_write,
    output logic             o_adr_src,
    output logic             o_mem_write,
    output logic             o_ir_write,
    output logic [1:0]       o_result_src,
    output logic [1:0]       o_alu_src_a,
    output logic [1:0]       o_alu_src_b,
    output logic [1:0]       o_imm_src,
    output logic [2:0]       o_alu_control,
    output logic             o_reg_write,
    output logic             o_fault,
    output logic [CNT_W-1:0] o_retired
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] retired_q;
    logic [1:0]       aluOp;
    logic             retireEvent;
    logic             pcWrite, memWrite, irWrite, regWrite;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (i_mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (i_op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTER;
                    OP_ITYPE:     state_d = S_EXECUTEI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_FAULT;
                endcase
            end
            S_MEMADR:   state_d = i_op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (i_mem_ready) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (i_mem_ready) state_d = S_FETCH;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_FAULT:    state_d = S_FAULT;
            default:    state_d = S_FAULT;
        endcase
    end

    // jal retires through ALUWB, so only the final state of each instruction counts.
    assign retireEvent = (state_q == S_MEMWB) || (state_q == S_ALUWB) || (state_q == S_BEQ) ||
                         ((state_q == S_MEMWRITE) && i_mem_ready);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (retireEvent) retired_q <= retired_q + CNT_W'(1);
        end
    end

    always_comb begin
        pcWrite      = 1'b0;
        o_adr_src    = 1'b0;
        memWrite     = 1'b0;
        irWrite      = 1'b0;
        o_result_src = RES_ALUOUT;
        o_alu_src_a  = SRCA_PC;
        o_alu_src_b  = SRCB_RS2;
        o_imm_src    = IMM_I;
        aluOp        = ALUOP_ADD;
        regWrite     = 1'b0;
        case (state_q)
            S_FETCH: begin
                o_alu_src_b  = SRCB_FOUR;
                o_result_src = RES_ALU;
                irWrite      = i_mem_ready;
                pcWrite      = i_mem_ready;
            end
            S_DECODE: begin
                o_alu_src_a = SRCA_OLDPC;
                o_alu_src_b = SRCB_IMM;
                o_imm_src   = IMM_B;
            end
            S_MEMADR: begin
                o_alu_src_a = SRCA_RS1;
                o_alu_src_b = SRCB_IMM;
                o_imm_src   = i_op[5] ? IMM_S : IMM_I;
            end
            S_MEMREAD:  o_adr_src = 1'b1;
            S_MEMWB: begin
                o_result_src = RES_DATA;
                regWrite     = 1'b1;
            end
            S_MEMWRITE: begin
                o_adr_src = 1'b1;
                memWrite  = 1'b1;
            end
            S_EXECUTER: begin
                o_alu_src_a = SRCA_RS1;
                aluOp       = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                o_alu_src_a = SRCA_RS1;
                o_alu_src_b = SRCB_IMM;
                aluOp       = ALUOP_FUNCT;
            end
            S_ALUWB:    regWrite = 1'b1;
            S_BEQ: begin
                o_alu_src_a = SRCA_RS1;
                aluOp       = ALUOP_SUB;
                pcWrite     = i_zero;
            end
            S_JAL: begin
                o_alu_src_a = SRCA_OLDPC;
                o_alu_src_b = SRCB_FOUR;
                o_imm_src   = IMM_J;
                pcWrite     = 1'b1;
            end
            default: ;
        endcase
    end

    riscv_alu_decoder u_alu_decoder (
        .alu_op_i      (aluOp),
        .funct3_i      (i_funct3),
        .op5_i         (i_op[5]),
        .funct7b5_i    (i_funct7b5),
        .alu_control_o (o_alu_control)
    );

    // Reset must suppress every write strobe even though FETCH would raise them.
    assign o_pc_write  = pcWrite  && !i_rst;
    assign o_ir_write  = irWrite  && !i_rst;
    assign o_mem_write = memWrite && !i_rst;
    assign o_reg_write = regWrite && !i_rst;
    assign o_fault     = (state_q == S_FAULT);
    assign o_retired   = retired_q;

endmodule

// File: tb/tb_riscv_mc_controller.sv
// Directed self-checking bench for riscv_mc_controller; a second CNT_W=3
// instance shares all inputs to exercise counter wrap.
module tb_riscv_mc_controller;

    logic        clock = 1'b0;
    logic        rst, zero, ready, f7b5;
    logic [6:0]  op;
    logic [2:0]  f3;

    logic        pcWrite, adrSrc, memWrite, irWrite, regWrite, fault;
    logic [1:0]  resultSrc, srcA, srcB, immSrc;
    logic [2:0]  aluControl;
    logic [31:0] retired;

    logic        sPcWrite, sAdrSrc, sMemWrite, sIrWrite, sRegWrite, sFault;
    logic [1:0]  sResultSrc, sSrcA, sSrcB, sImmSrc;
    logic [2:0]  sAluControl;
    logic [2:0]  sRetired;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    always #5 clock = ~clock;

    riscv_mc_controller dut (
        .i_clk(clock), .i_rst(rst), .i_op(op), .i_funct3(f3), .i_funct7b5(f7b5),
        .i_zero(zero), .i_mem_ready(ready),
        .o_pc_write(pcWrite), .o_adr_src(adrSrc), .o_mem_write(memWrite), .o_ir_write(irWrite),
        .o_result_src(resultSrc), .o_alu_src_a(srcA), .o_alu_src_b(srcB), .o_imm_src(immSrc),
        .o_alu_control(aluControl), .o_reg_write(regWrite), .o_fault(fault), .o_retired(retired)
    );

    riscv_mc_controller #(.CNT_W(3)) dutSmall (
        .i_clk(clock), .i_rst(rst), .i_op(op), .i_funct3(f3), .i_funct7b5(f7b5),
        .i_zero(zero), .i_mem_ready(ready),
        .o_pc_write(sPcWrite), .o_adr_src(sAdrSrc), .o_mem_write(sMemWrite), .o_ir_write(sIrWrite),
        .o_result_src(sResultSrc), .o_alu_src_a(sSrcA), .o_alu_src_b(sSrcB), .o_imm_src(sImmSrc),
        .o_alu_control(sAluControl), .o_reg_write(sRegWrite), .o_fault(sFault), .o_retired(sRetired)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Packs all strobes of the main instance in port order for one comparison.
    task automatic checkStrobes(input string tag, input logic pcw, input logic adr, input logic mw,
                                input logic irw, input logic [1:0] rs, input logic [1:0] sa,
                                input logic [1:0] sb, input logic [1:0] imm, input logic [2:0] alu,
                                input logic rw, input logic flt);
        checkOutput(tag,
            {15'b0, pcWrite, adrSrc, memWrite, irWrite, resultSrc, srcA, srcB, immSrc, aluControl, regWrite, fault},
            {15'b0, pcw, adr, mw, irw, rs, sa, sb, imm, alu, rw, flt});
    endtask

    task automatic applyStimulus(input logic [6:0] opV, input logic [2:0] f3V, input logic f7V,
                                 input logic zeroV, input logic readyV);
        op = opV; f3 = f3V; f7b5 = f7V; zero = zeroV; ready = readyV;
        #1;
    endtask

    task automatic applyReset(input logic r);
        rst = r;
        #1;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        rst = 1'b1; op = 7'b0000011; f3 = 3'b010; f7b5 = 1'b0; zero = 1'b0; ready = 1'b1;
        #1;
        // Reset held with ready high: FETCH decode, but no write strobes.
        checkStrobes("reset_strobes", 0,0,0,0, 2'b10,2'b00,2'b10,2'b00, 3'b000, 0,0);
        checkOutput("reset_retired", retired, 32'd0);
        checkOutput("reset_retired_small", {29'b0, sRetired}, 32'd0);
        tick();
        applyReset(1'b0);

        // lw: FETCH DECODE MEMADR MEMREAD MEMWB
        checkStrobes("lw_fetch", 1,0,0,1, 2'b10,2'b00,2'b10,2'b00, 3'b000, 0,0);
        tick(); checkStrobes("lw_decode", 0,0,0,0, 2'b00,2'b01,2'b01,2'b10, 3'b000, 0,0);
        tick(); checkStrobes("lw_memadr", 0,0,0,0, 2'b00,2'b10,2'b01,2'b00, 3'b000, 0,0);
        tick(); checkStrobes("lw_memread", 0,1,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000, 0,0);
        tick(); checkStrobes("lw_memwb", 0,0,0,0, 2'b01,2'b00,2'b00,2'b00, 3'b000, 1,0);
        checkOutput("lw_retired_before", retired, 32'd0);
        tick(); checkStrobes("lw_back_fetch", 1,0,0,1, 2'b10,2'b00,2'b10,2'b00, 3'b000, 0,0);
        checkOutput("lw_retired_after", retired, 32'd1);

        // R-type sub
        applyStimulus(7'b0110011, 3'b000, 1'b1, 1'b0, 1'b1);
        tick(); checkStrobes("r_decode", 0,0,0,0, 2'b00,2'b01,2'b01,2'b10, 3'b000, 0,0);
        tick(); checkStrobes("r_sub_exec", 0,0,0,0, 2'b00,2'b10,2'b00,2'b00, 3'b001, 0,0);
        tick(); checkStrobes("r_aluwb", 0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000, 1,0);
        tick(); checkOutput("r_retired", retired, 32'd2);

        // I-type with instr[30]=1 stays add
        applyStimulus(7'b0010011, 3'b000, 1'b1, 1'b0, 1'b1);
        tick(); tick(); checkStrobes("i_add_exec", 0,0,0,0, 2'b00,2'b10,2'b01,2'b00, 3'b000, 0,0);
        tick(); checkStrobes("i_aluwb", 0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000, 1,0);
        tick(); checkOutput("i_retired", retired, 32'd3);

        // beq taken
        applyStimulus(7'b1100011, 3'b000, 1'b0, 1'b1, 1'b1);
        tick(); checkStrobes("beq_decode_no_pcw", 0,0,0,0, 2'b00,2'b01,2'b01,2'b10, 3'b000, 0,0);
        tick(); checkStrobes("beq_taken", 1,0,0,0, 2'b00,2'b10,2'b00,2'b00, 3'b001, 0,0);
        tick(); checkStrobes("beq_taken_fetch", 1,0,0,1, 2'b10,2'b00,2'b10,2'b00, 3'b000, 0,0);
        checkOutput("beq_taken_retired", retired, 32'd4);

        // beq not taken
        applyStimulus(7'b1100011, 3'b000, 1'b0, 1'b0, 1'b1);
        tick(); tick(); checkStrobes("beq_not_taken", 0,0,0,0, 2'b00,2'b10,2'b00,2'b00, 3'b001, 0,0);
        tick(); checkStrobes("beq_nt_fetch", 1,0,0,1, 2'b10,2'b00,2'b10,2'b00, 3'b000, 0,0);
        checkOutput("beq_nt_retired", retired, 32'd5);

        // jal through ALUWB
        applyStimulus(7'b1101111, 3'b000, 1'b0, 1'b0, 1'b1);
        tick(); tick(); checkStrobes("jal_state", 1,0,0,0, 2'b00,2'b01,2'b10,2'b11, 3'b000, 0,0);
        tick(); checkStrobes("jal_aluwb", 0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000, 1,0);
        checkOutput("jal_retired_before", retired, 32'd5);
        tick(); checkOutput("jal_retired", retired, 32'd6);

        // sw with a fetch stall and three not-ready MEMWRITE cycles
        applyStimulus(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0);
        checkStrobes("fetch_stall", 0,0,0,0, 2'b10,2'b00,2'b10,2'b00, 3'b000, 0,0);
        tick(); checkStrobes("fetch_stall_hold", 0,0,0,0, 2'b10,2'b00,2'b10,2'b00, 3'b000, 0,0);
        applyStimulus(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b1);
        tick(); tick(); checkStrobes("sw_memadr", 0,0,0,0, 2'b00,2'b10,2'b01,2'b01, 3'b000, 0,0);
        applyStimulus(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            checkStrobes($sformatf("sw_wait%0d", i), 0,1,1,0, 2'b00,2'b00,2'b00,2'b00, 3'b000, 0,0);
            checkOutput($sformatf("sw_wait_retired%0d", i), retired, 32'd6);
            tick();
        end
        applyStimulus(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b1);
        checkStrobes("sw_ready", 0,1,1,0, 2'b00,2'b00,2'b00,2'b00, 3'b000, 0,0);
        tick(); checkStrobes("sw_fetch", 1,0,0,1, 2'b10,2'b00,2'b10,2'b00, 3'b000, 0,0);
        checkOutput("sw_retired", retired, 32'd7);

        // R-type and, I-type or
        applyStimulus(7'b0110011, 3'b111, 1'b0, 1'b0, 1'b1);
        tick(); tick(); checkStrobes("r_and_exec", 0,0,0,0, 2'b00,2'b10,2'b00,2'b00, 3'b010, 0,0);
        tick(); tick();
        applyStimulus(7'b0010011, 3'b110, 1'b0, 1'b0, 1'b1);
        tick(); tick(); checkStrobes("i_or_exec", 0,0,0,0, 2'b00,2'b10,2'b01,2'b00, 3'b011, 0,0);
        tick(); tick();
        checkOutput("nine_retired", retired, 32'd9);
        checkOutput("small_wrap", {29'b0, sRetired}, 32'd1);

        // Reset mid-MEMREAD
        applyStimulus(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b1);
        tick(); tick();
        applyStimulus(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0);
        tick(); checkStrobes("memread_wait", 0,1,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000, 0,0);
        applyStimulus(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b1);
        applyReset(1'b1);
        checkStrobes("midreset_strobes", 0,0,0,0, 2'b10,2'b00,2'b10,2'b00, 3'b000, 0,0);
        checkOutput("midreset_retired", retired, 32'd0);
        checkOutput("midreset_retired_small", {29'b0, sRetired}, 32'd0);
        tick();
        applyReset(1'b0);
        checkStrobes("post_reset_fetch", 1,0,0,1, 2'b10,2'b00,2'b10,2'b00, 3'b000, 0,0);

        // Illegal opcode into FAULT
        applyStimulus(7'b1111111, 3'b000, 1'b0, 1'b1, 1'b1);
        tick(); tick();
        for (int i = 0; i < 20; i++) begin
            checkStrobes($sformatf("fault_hold%0d", i), 0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000, 0,1);
            tick();
        end
        checkOutput("fault_retired", retired, 32'd0);
        applyReset(1'b1);
        checkOutput("fault_cleared", {31'b0, fault}, 32'd0);
        tick();
        applyReset(1'b0);
        checkStrobes("fault_reset_fetch", 1,0,0,1, 2'b10,2'b00,2'b10,2'b00, 3'b000, 0,0);
        checkOutput("fault_reset_retired", retired, 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
